// File: rtl/ft_sync_fifo_arbiter.sv
// FT2232H synchronous FIFO (FT245-sync) bus controller.
// Shares the 8-bit bidirectional pad bus between host->FPGA reads and FPGA->host writes.
// Bursts are bounded, and the direction alternates whenever both sides have work.

module ft_sync_fifo_arbiter #(
   parameter int unsigned DATA_W    = 8,
   parameter int unsigned MAX_BURST = 64,
   parameter int unsigned CNT_W     = 7
) (
   input  logic              i_comm_clk,
   input  logic              i_rst_n,
   input  logic              i_rxf_n,
   input  logic              i_txe_n,
   input  logic [DATA_W-1:0] i_data_in,
   output logic [DATA_W-1:0] o_data_out,
   output logic              o_data_oe,
   output logic              o_oe_n,
   output logic              o_rd_n,
   output logic              o_wr_n,
   input  logic [DATA_W-1:0] i_tx_data,
   input  logic              i_tx_valid,
   output logic              o_tx_ready,
   output logic [DATA_W-1:0] o_rx_data,
   output logic              o_rx_valid,
   input  logic              i_rx_afull,
   output logic              o_busy
);

   typedef enum logic [2:0] {
      StIdle,
      StRxOe,
      StRxRead,
      StRxEnd,
      StTurn,
      StTxWrite,
      StTxEnd
   } state_t;

   localparam logic [CNT_W-1:0] MaxBurstC = CNT_W'(MAX_BURST);
   localparam logic [CNT_W-1:0] CntSatC   = {CNT_W{1'b1}};
   // Consecutive txe_n-high cycles after which a TX burst yields to pending RX
   localparam logic [2:0]       YieldCycC = 3'd4;

   state_t            r_state;
   logic [CNT_W-1:0]  r_cnt;
   logic [2:0]        r_txe_hi;
   logic              r_last_rx;
   logic              r_hold_valid;
   logic [DATA_W-1:0] r_hold_data;
   logic              r_oe_n;
   logic              r_rd_n;
   logic              r_wr_n;
   logic              r_data_oe;
   logic [DATA_W-1:0] r_rx_data;
   logic              r_rx_valid;

   logic              w_rx_req;
   logic              w_tx_req;
   logic              w_rx_xfer;
   logic              w_tx_xfer;
   logic              w_tx_ready;
   logic              w_tx_pop;
   logic              w_hold_valid_nxt;
   logic [CNT_W-1:0]  w_cnt_inc;
   logic [CNT_W-1:0]  w_rx_cnt_nxt;
   logic [CNT_W-1:0]  w_tx_cnt_nxt;
   logic [2:0]        w_txe_hi_nxt;
   logic              w_rx_done;
   logic              w_tx_done;

   // Requests, transfer qualifiers and burst-exit conditions
   always_comb begin
      w_rx_req  = !i_rxf_n && !i_rx_afull;
      // A byte left in the hold register also counts as TX work
      w_tx_req  = !i_txe_n && (i_tx_valid || r_hold_valid);
      // rd_n/wr_n are only ever low in RX_READ/TX_WRITE, so no state term is needed
      w_rx_xfer = !r_rd_n && !i_rxf_n;
      w_tx_xfer = !r_wr_n && !i_txe_n;

      w_tx_ready       = (r_state == StTxWrite) && (!r_hold_valid || w_tx_xfer);
      w_tx_pop         = w_tx_ready && i_tx_valid;
      w_hold_valid_nxt = w_tx_pop || (r_hold_valid && !w_tx_xfer);

      w_cnt_inc    = (r_cnt == CntSatC) ? r_cnt : r_cnt + 1'b1;
      w_rx_cnt_nxt = w_rx_xfer ? w_cnt_inc : r_cnt;
      w_tx_cnt_nxt = w_tx_xfer ? w_cnt_inc : r_cnt;

      if (!i_txe_n) begin
         w_txe_hi_nxt = 3'd0;
      end else if (r_txe_hi == 3'b111) begin
         w_txe_hi_nxt = r_txe_hi;
      end else begin
         w_txe_hi_nxt = r_txe_hi + 3'd1;
      end

      w_rx_done = i_rxf_n || i_rx_afull || (w_rx_cnt_nxt >= MaxBurstC);
      w_tx_done = (w_tx_cnt_nxt >= MaxBurstC) || !w_hold_valid_nxt ||
                  ((w_txe_hi_nxt >= YieldCycC) && !i_rxf_n);
   end

   // Bus FSM with registered strobes, RX capture and TX hold register
   always_ff @(posedge i_comm_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state      <= StIdle;
         r_cnt        <= '0;
         r_txe_hi     <= 3'd0;
         r_last_rx    <= 1'b0;
         r_hold_valid <= 1'b0;
         r_hold_data  <= '0;
         r_oe_n       <= 1'b1;
         r_rd_n       <= 1'b1;
         r_wr_n       <= 1'b1;
         r_data_oe    <= 1'b0;
         r_rx_data    <= '0;
         r_rx_valid   <= 1'b0;
      end else begin
         r_rx_valid <= 1'b0;
         if (w_rx_xfer) begin
            r_rx_data  <= i_data_in;
            r_rx_valid <= 1'b1;
         end
         r_hold_valid <= w_hold_valid_nxt;
         if (w_tx_pop) begin
            r_hold_data <= i_tx_data;
         end

         unique case (r_state)
            StIdle: begin
               // Both requesting: go opposite to the previous direction
               if (w_rx_req && (!w_tx_req || !r_last_rx)) begin
                  r_state   <= StRxOe;
                  r_oe_n    <= 1'b0;
                  r_cnt     <= '0;
                  r_last_rx <= 1'b1;
               end else if (w_tx_req) begin
                  r_state   <= StTxWrite;
                  r_data_oe <= 1'b1;
                  r_wr_n    <= !r_hold_valid;
                  r_cnt     <= '0;
                  r_txe_hi  <= 3'd0;
                  r_last_rx <= 1'b0;
               end
            end
            StRxOe: begin
               r_state <= StRxRead;
               r_rd_n  <= 1'b0;
            end
            StRxRead: begin
               r_cnt <= w_rx_cnt_nxt;
               if (w_rx_done) begin
                  r_state <= StRxEnd;
                  r_rd_n  <= 1'b1;
               end
            end
            StRxEnd: begin
               r_state <= StTurn;
               r_oe_n  <= 1'b1;
            end
            StTurn: begin
               r_state <= StIdle;
            end
            StTxWrite: begin
               r_cnt    <= w_tx_cnt_nxt;
               r_txe_hi <= w_txe_hi_nxt;
               if (w_tx_done) begin
                  r_state <= StTxEnd;
                  r_wr_n  <= 1'b1;
               end else begin
                  r_wr_n <= !w_hold_valid_nxt;
               end
            end
            StTxEnd: begin
               r_state   <= StTurn;
               r_data_oe <= 1'b0;
            end
            default: begin
               r_state <= StIdle;
            end
         endcase
      end
   end

   assign o_data_out = r_hold_data;
   assign o_data_oe  = r_data_oe;
   assign o_oe_n     = r_oe_n;
   assign o_rd_n     = r_rd_n;
   assign o_wr_n     = r_wr_n;
   assign o_tx_ready = w_tx_ready;
   assign o_rx_data  = r_rx_data;
   assign o_rx_valid = r_rx_valid;
   assign o_busy     = (r_state != StIdle);

endmodule
